// File: rtl/flux_pkg.sv
// Shared token values, widths, FSM state and FIFO entry layout for the flux capture path.
package flux_pkg;

   localparam int unsigned TOK_W      = 16;
   localparam int unsigned WORD_W     = 64;
   localparam int unsigned LANE_IDX_W = 2;
   localparam int unsigned LANE_CNT_W = 3;

   localparam logic [TOK_W-1:0] FLUX_TOK_INDEX = 16'h0000;
   localparam logic [TOK_W-1:0] FLUX_TOK_CONT  = 16'hFFFF;
   localparam logic [TOK_W-1:0] FLUX_CNT_MAX   = 16'hFFFE;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      CAPTURE,
      FLUSH
   } flux_state_e;

   typedef struct packed {
      logic [WORD_W-1:0]     data;
      logic [LANE_CNT_W-1:0] lanes;
      logic                  last;
   } flux_entry_t;

endpackage

// File: rtl/flux_tx_fifo.sv
// First-word-fall-through FIFO of packed flux words with a registered head/valid/full.
module flux_tx_fifo
   import flux_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  flux_entry_t push_data,
   output logic        full,
   input  logic        pop,
   output flux_entry_t pop_data,
   output logic        valid
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   flux_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok_c, push_ok_c;
   flux_entry_t   head_d;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   always_comb begin
      pop_ok_c  = pop && valid;
      push_ok_c = push && (!full || pop_ok_c);
      rd_ptr_d  = rd_ptr_q + AW'(pop_ok_c);
      wr_ptr_d  = wr_ptr_q + AW'(push_ok_c);
      count_d   = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
      head_d    = '0;
      if (count_d != '0) begin
         if (count_q == CW'(pop_ok_c)) head_d = push_data;
         else                          head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pop_data <= '0;
         valid    <= 1'b0;
         full     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pop_data <= head_d;
         valid    <= (count_d != '0);
         full     <= (count_d == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/flux_capture_tx.sv
// Floppy RDATA flux capture: interval tokens packed four per 64-bit word into a FWFT FIFO.
// Define FLUX_INDEX_MARK_EN to insert 0x0000 markers on drive index pulses.
module flux_capture_tx
   import flux_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdata_n,
   input  logic        index_n,
   input  logic        capture_en,
   input  logic        overflow_clr,
   output logic [63:0] tx_data,
   output logic [2:0]  tx_lanes,
   output logic        tx_last,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        overflow,
   output logic        busy
);

   flux_state_e            state_q, state_d;
   logic [SYNC_STAGES-1:0] rd_sync_q;
   logic                   rd_prev_q;
   logic                   flux_ev_c;
   logic                   cap_q;
   logic                   cap_rise_c;
   logic [TOK_W-1:0]       d_q, d_d, d_inc_c;
   logic                   tok_vld_c;
   logic [TOK_W-1:0]       tok_c;
   logic [LANE_IDX_W-1:0]  lane_q, lane_d;
   logic [WORD_W-1:0]      pk_q, pk_d, pk_fill_c;
   logic                   word_done_c;
   logic                   push_q;
   flux_entry_t            stage_q, stage_d;
   logic                   can_push_c, fifo_push_c, drop_c, flush_done_c;
   logic                   fifo_full;
   flux_entry_t            fifo_wdata_c, fifo_head;
   logic                   overflow_d;

   // Read-data synchronizer; the pin idles high so the chain resets to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sync_q <= '1;
         rd_prev_q <= 1'b1;
      end else begin
         rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rdata_n};
         rd_prev_q <= rd_sync_q[SYNC_STAGES-1];
      end
   end

   assign flux_ev_c  = rd_prev_q & ~rd_sync_q[SYNC_STAGES-1];
   assign cap_rise_c = capture_en & ~cap_q;

`ifdef FLUX_INDEX_MARK_EN
   logic [SYNC_STAGES-1:0] ix_sync_q;
   logic                   ix_prev_q;
   logic                   idx_ev_c;
   logic                   idx_pend_q, idx_pend_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ix_sync_q <= '1;
         ix_prev_q <= 1'b1;
      end else begin
         ix_sync_q <= {ix_sync_q[SYNC_STAGES-2:0], index_n};
         ix_prev_q <= ix_sync_q[SYNC_STAGES-1];
      end
   end

   assign idx_ev_c = ix_prev_q & ~ix_sync_q[SYNC_STAGES-1];
`else
   logic unused_index_c;
   assign unused_index_c = index_n;
`endif

   // Token generation, distance counter and lane packer.
   always_comb begin
      d_inc_c   = d_q + 16'd1;
      d_d       = d_q;
      tok_vld_c = 1'b0;
      tok_c     = FLUX_TOK_INDEX;
`ifdef FLUX_INDEX_MARK_EN
      idx_pend_d = 1'b0;
`endif
      case (state_q)
         IDLE: d_d = '0;
         ARM:  d_d = '0;
         CAPTURE: begin
            if (flux_ev_c) begin
               tok_vld_c = 1'b1;
               tok_c     = d_inc_c;
               d_d       = '0;
            end else if (d_inc_c == FLUX_CNT_MAX) begin
               tok_vld_c = 1'b1;
               tok_c     = FLUX_TOK_CONT;
               d_d       = '0;
            end else begin
               d_d = d_inc_c;
            end
         end
         default: d_d = d_q;
      endcase
`ifdef FLUX_INDEX_MARK_EN
      // Flux tokens win the slot; a marker waits (and merges) until a free cycle.
      if (state_q == ARM || state_q == CAPTURE) begin
         if (tok_vld_c) begin
            idx_pend_d = idx_pend_q | idx_ev_c;
         end else if (idx_pend_q | idx_ev_c) begin
            tok_vld_c = 1'b1;
            tok_c     = FLUX_TOK_INDEX;
         end
      end
`endif
      pk_fill_c = pk_q;
      pk_fill_c[{lane_q, 4'b0000} +: TOK_W] = tok_c;
      word_done_c = tok_vld_c && (lane_q == 2'd3);

      lane_d  = lane_q;
      pk_d    = pk_q;
      stage_d = stage_q;
      if (state_q == IDLE) begin
         lane_d = '0;
         pk_d   = '0;
      end else if (word_done_c) begin
         lane_d  = '0;
         pk_d    = '0;
         stage_d = '{data: pk_fill_c, lanes: 3'd4, last: 1'b0};
      end else if (tok_vld_c) begin
         lane_d = lane_q + 2'd1;
         pk_d   = pk_fill_c;
      end

      // Full capture words are dropped when blocked; the terminating word waits instead.
      can_push_c   = !fifo_full || tx_ready;
      fifo_push_c  = 1'b0;
      drop_c       = 1'b0;
      flush_done_c = 1'b0;
      fifo_wdata_c = stage_q;
      if (push_q && state_q != IDLE) begin
         if (can_push_c) fifo_push_c = 1'b1;
         else            drop_c      = 1'b1;
      end else if (state_q == FLUSH && can_push_c) begin
         fifo_push_c  = 1'b1;
         flush_done_c = 1'b1;
         fifo_wdata_c = '{data: pk_q, lanes: {1'b0, lane_q}, last: 1'b1};
      end

      overflow_d = overflow;
      if (drop_c)
         overflow_d = 1'b1;
      else if (overflow_clr || (state_q == IDLE && cap_rise_c))
         overflow_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cap_rise_c) state_d = ARM;
         ARM: begin
            if (!capture_en)    state_d = IDLE;
            else if (flux_ev_c) state_d = CAPTURE;
         end
         CAPTURE: if (!capture_en) state_d = FLUSH;
         FLUSH:   if (flush_done_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q    <= 1'b0;
         d_q      <= '0;
         lane_q   <= '0;
         pk_q     <= '0;
         push_q   <= 1'b0;
         stage_q  <= '0;
         overflow <= 1'b0;
      end else begin
         cap_q    <= capture_en;
         d_q      <= d_d;
         lane_q   <= lane_d;
         pk_q     <= pk_d;
         push_q   <= word_done_c;
         stage_q  <= stage_d;
         overflow <= overflow_d;
      end
   end

`ifdef FLUX_INDEX_MARK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx_pend_q <= 1'b0;
      else        idx_pend_q <= idx_pend_d;
   end
`endif

   flux_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push_c),
      .push_data (fifo_wdata_c),
      .full      (fifo_full),
      .pop       (tx_ready),
      .pop_data  (fifo_head),
      .valid     (tx_valid)
   );

   assign tx_data  = fifo_head.data;
   assign tx_lanes = fifo_head.lanes;
   assign tx_last  = fifo_head.last;

endmodule
